// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, MSB-first payload, ready/valid output.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA      = 8,
    parameter int CLK_RATE  = 153600,
    parameter int BAUD_RATE = 9600
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    input  logic            rx_ready,
    output logic [DATA-1:0] rx_data,
    output logic            rx_valid,
    output logic            parity_err,
    output logic            frame_err,
    output logic            overrun_err,
    output logic            busy
);
    localparam int OS     = CLK_RATE / BAUD_RATE;
    localparam int TICK_W = (OS > 1) ? $clog2(OS) : 1;
    localparam int BIT_W  = $clog2(DATA + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OS / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              armed_q, armed_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA-1:0]   shift_q, shift_d;
    logic [DATA-1:0]   data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              oerr_q, oerr_d;
    logic              busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic              par_chk_q, par_chk_d;
    logic              perr_q, perr_d;
`endif
    logic              rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        sync1_d  = rx;
        sync2_d  = sync1_q;
        state_d  = state_q;
        armed_d  = armed_q;
        tick_d   = tick_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        oerr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk_d = par_chk_q;
        perr_d    = perr_q;
`endif

        if (rx_s) begin
            armed_d = 1'b1;
        end
        // Accept clears first so a same-cycle load below overrides it.
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (!rx_s && armed_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick_q == TICK_MID) begin
                    tick_d  = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    shift_d = {shift_q[DATA-2:0], rx_s};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d    = '0;
                    par_chk_d = (^shift_q) ^ rx_s;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    state_d = S_IDLE;
                    if (rx_s) begin
                        if (!valid_q || rx_ready) begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
                            perr_d  = par_chk_q;
`endif
                        end else begin
                            oerr_d = 1'b1;
                        end
                    end else begin
                        // Line is stuck low: wait for it to go high before rearming.
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            armed_q   <= 1'b1;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            oerr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_chk_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            armed_q   <= armed_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            oerr_q    <= oerr_d;
            busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_chk_q <= par_chk_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
    assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected words/error pulses, a negedge monitor pops and checks.
module tb_uart_rx;
    localparam int DATA = 8;
    localparam int OS   = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int LAT = OS / 2 + OS * (DATA + 1 + PAR_EN);

    localparam int K_WORD = 0;
    localparam int K_FERR = 1;
    localparam int K_OERR = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            rx;
    logic            rx_ready;
    logic [DATA-1:0] rx_data;
    logic            rx_valid;
    logic            parity_err;
    logic            frame_err;
    logic            overrun_err;
    logic            busy;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        int         cyc;
    } word_t;

    typedef struct {
        int kind;
        int cyc;
    } err_t;

    word_t wq[$];
    err_t  eq[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    uart_rx #(
        .DATA(DATA),
        .CLK_RATE(153600),
        .BAUD_RATE(9600)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .overrun_err(overrun_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame starting right after a clock edge; expected event cycle is fixed at the start.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int kind, input logic exp_perr, input bit chk_cyc);
        int    c;
        word_t w;
        err_t  e;
        rx = 1'b0;
        c  = cyc;
        if (kind == K_WORD) begin
            w.data = d;
            w.perr = exp_perr;
            w.cyc  = chk_cyc ? c + 3 + LAT : 0;
            wq.push_back(w);
        end else begin
            e.kind = kind;
            e.cyc  = c + 3 + LAT;
            eq.push_back(e);
        end
        repeat (OS) step();
        for (int i = 7; i >= 0; i--) begin
            rx = d[i];
            repeat (OS) step();
        end
        if (PAR_EN != 0) begin
            rx = par;
            repeat (OS) step();
        end
        rx = stop;
        repeat (OS) step();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) begin
                if (wq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL word_unexpected: got data 0x%0h, none expected", rx_data);
                end else begin
                    word_t w;
                    w = wq.pop_front();
                    chk("word_data", 32'(rx_data), 32'(w.data));
                    chk("word_parity_err", 32'(parity_err), 32'(w.perr));
                    if (w.cyc != 0) chk("word_latency", cyc, w.cyc);
                end
            end
            if (frame_err || overrun_err) begin
                if (eq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL err_unexpected: got frame_err=%0b overrun_err=%0b, none expected",
                             frame_err, overrun_err);
                end else begin
                    err_t e;
                    e = eq.pop_front();
                    chk("err_kind", overrun_err ? K_OERR : K_FERR, e.kind);
                    chk("err_both", 32'(frame_err & overrun_err), 32'h0);
                    chk("err_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int c;
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        repeat (3) step();
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        chk("rst_parity_err", 32'(parity_err), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_overrun_err", 32'(overrun_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (4) step();

        // 0xA5 (four ones): parity bit 0 is correct
        send_frame(8'hA5, 1'b0, 1'b1, K_WORD, 1'b0, 1'b1);
        repeat (20) step();

        // 0x3C (four ones): parity bit 1 is wrong
        send_frame(8'h3C, 1'b1, 1'b1, K_WORD, (PAR_EN != 0) ? 1'b1 : 1'b0, 1'b1);
        repeat (20) step();

        // Short glitch: start rejected at mid-bit, nothing reported
        rx = 1'b0;
        c  = cyc;
        repeat (4) step();
        rx = 1'b1;
        repeat (6) step();
        chk("glitch_busy_high", 32'(busy), 32'h1);
        chk("glitch_cycle", cyc, c + 10);
        step();
        chk("glitch_busy_low", 32'(busy), 32'h0);
        repeat (20) step();

        // Stop bit low: frame error, no restart while line stays low
        send_frame(8'h81, 1'b0, 1'b0, K_FERR, 1'b0, 1'b0);
        repeat (40) step();
        chk("ferr_line_low_busy", 32'(busy), 32'h0);
        chk("ferr_rx_valid", 32'(rx_valid), 32'h0);
        rx = 1'b1;
        repeat (20) step();
        send_frame(8'h42, 1'b0, 1'b1, K_WORD, 1'b0, 1'b1);
        repeat (20) step();

        // Overrun: consumer stalled across two frames
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, K_WORD, 1'b0, 1'b0);
        repeat (10) step();
        send_frame(8'h22, 1'b0, 1'b1, K_OERR, 1'b0, 1'b0);
        repeat (10) step();
        chk("ovr_held_data", 32'(rx_data), 32'h11);
        chk("ovr_held_valid", 32'(rx_valid), 32'h1);
        rx_ready = 1'b1;
        step();
        chk("ovr_valid_falls", 32'(rx_valid), 32'h0);
        repeat (10) step();

        // Reset after four data bits of 0x5A, then a clean 0x5A
        rx = 1'b0;
        repeat (OS) step();
        rx = 1'b0; repeat (OS) step();
        rx = 1'b1; repeat (OS) step();
        rx = 1'b0; repeat (OS) step();
        rx = 1'b1; repeat (OS) step();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) step();
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_rx_valid", 32'(rx_valid), 32'h0);
        chk("midrst_rx_data", 32'(rx_data), 32'h0);
        rst = 1'b0;
        repeat (5) step();
        send_frame(8'h5A, 1'b0, 1'b1, K_WORD, 1'b0, 1'b1);
        repeat (30) step();

        chk("words_outstanding", wq.size(), 0);
        chk("errs_outstanding", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA, default 8: number of payload bits per frame.
REQ-002 SHALL have parameter CLK_RATE, default 153600: clk frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 9600: serial bit rate; OS = CLK_RATE/BAUD_RATE is the number of clk cycles per bit, default 16.
REQ-004 SHALL have port clk  input  1  single clock; all flops on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts the held word when high with rx_valid.
REQ-008 SHALL have port rx_data  output  DATA  received word, MSB first on the line.
REQ-009 SHALL have port rx_valid  output  1  rx_data and parity_err hold a word not yet accepted.
REQ-010 SHALL have port parity_err  output  1  parity status of the held word; meaningful only while rx_valid is high.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-012 SHALL have port overrun_err  output  1  one-cycle pulse when a good frame completes while rx_valid is already high.
REQ-013 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer, reset value 1; all references to rx below mean the synchronized value.
REQ-015 SHALL have states IDLE, START, DATA, PARITY, STOP, with a tick counter of width clog2(OS) and a bit counter of width clog2(DATA+1).
REQ-016 IDLE -> START SHALL occur on the first cycle rx is 0, provided the line was sampled high at least once since the last frame or reset (armed flag).
REQ-017 START SHALL sample rx when tick == OS/2-1: if 0, go to DATA with tick cleared; if 1 (glitch), go to IDLE with nothing reported.
REQ-018 DATA SHALL sample rx every OS cycles, shifting MSB first; after DATA samples go to PARITY when UART_RX_PARITY_EN is defined, else go to STOP.
REQ-019 PARITY SHALL sample one bit OS cycles after the last data sample and compare it to the XOR of the received data bits (even parity).
REQ-020 STOP SHALL sample rx OS cycles after the previous sample, then return to IDLE on the next cycle.
REQ-021 If the stop sample is 1 and rx_valid is 0, the block SHALL load rx_data and parity_err and assert rx_valid on the cycle after the stop sample.
REQ-022 If the stop sample is 1 and rx_valid is 1, the block SHALL drop the new word, keep the held word, and pulse overrun_err for one cycle.
REQ-023 If the stop sample is 0, the block SHALL drop the word, pulse frame_err for one cycle, and clear the armed flag.
REQ-024 rx_valid SHALL clear on the cycle after rx_valid && rx_ready; if a load and an accept occur in the same cycle, the new word SHALL be loaded and rx_valid SHALL stay 1, with no overrun.
REQ-025 Latency: with T0 the first IDLE cycle seeing rx == 0, rx_valid SHALL rise at T0+OS/2+OS*(DATA+2) with parity enabled (168 at defaults) and at T0+OS/2+OS*(DATA+1) without it (152).

Reset
REQ-026 Asserting rst at any time, including mid-frame, SHALL force IDLE, clear both counters and the shift register, and set the synchronizer flops and the armed flag to 1.
REQ-027 Reset output values SHALL be: rx_data 0, rx_valid 0, parity_err 0, frame_err 0, overrun_err 0, busy 0; a partial frame SHALL NOT be reported.

Configuration
REQ-028 With UART_RX_PARITY_EN defined, the frame SHALL be start + DATA + parity + stop, and parity_err SHALL reflect the parity check.
REQ-029 Without UART_RX_PARITY_EN, the frame SHALL be start + DATA + stop, the PARITY state SHALL be absent, and parity_err SHALL be tied 0.

Verification
REQ-030 Parity on, rx_ready=1: send 0xA5 with parity 0 and stop 1 -> rx_data=0xA5, rx_valid high for 1 cycle at T0+168, parity_err=0.
REQ-031 Parity on: send 0x3C with parity bit 1 -> rx_data=0x3C, rx_valid=1, parity_err=1.
REQ-032 Drive rx low for 4 cycles, then high -> no rx_valid, no error pulse, busy returns to 0 after OS/2 cycles.
REQ-033 Send 0x81 with stop bit 0 -> frame_err pulses once, rx_valid stays 0, and no new start is accepted until rx has returned high.
REQ-034 rx_ready=0: send 0x11 then 0x22 -> rx_data stays 0x11 and overrun_err pulses once at the end of frame 2; then assert rx_ready -> rx_valid falls.
REQ-035 Assert rst after 4 data bits, then send 0x5A -> no output from the partial frame; 0x5A is received correctly.
